// File: rtl/pla_sel_monitor.sv
// Monitors the PLA's delayed active-low chip selects in the clk_i domain:
// counts runt pulses and decode-conflict episodes and captures the first fault.
module pla_sel_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_PULSE     = 4,
    parameter int CW            = 16,
    parameter int FREEZE_ON_ERR = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [7:0]    sel_n_i,
    output logic [CW-1:0] glitch_cnt_o,
    output logic [CW-1:0] conflict_cnt_o,
    output logic          err_o,
    output logic [1:0]    err_type_o,
    output logic [7:0]    err_vec_o,
    output logic [1:0]    state_o
);
    localparam int            WW       = $clog2(MIN_PULSE + 1);
    localparam logic [7:0]    ROM_MASK = 8'h77;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  sel_p_q, sel_p_d;
    logic [7:0][WW-1:0]          w_q, w_d;
    logic [7:0]                  glt_q, glt_d;
    logic                        multi_q, multi_d, ramrom_q, ramrom_d;
    logic                        conf_p_q, conf_p_d, was_run_q, was_run_d;
    logic [7:0]                  vec_q, vec_d;
    state_t                      state_q, state_d;
    logic [CW-1:0]               glitch_cnt_q, glitch_cnt_d, conflict_cnt_q, conflict_cnt_d;
    logic                        err_q, err_d;
    logic [1:0]                  err_type_q, err_type_d;
    logic [7:0]                  err_vec_q, err_vec_d;

    logic [7:0]  sel_s, rom_lo;
    logic [3:0]  glt_n;
    logic [CW:0] gsum;
    logic        conf_start, fault;

    always_comb begin
        sync_d[0] = sel_n_i;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        sel_s   = sync_q[SYNC_STAGES-1];
        sel_p_d = sel_s;

        // Detection stage: width tracking, runt edges and conflict levels,
        // registered once before the counters see them.
        for (int i = 0; i < 8; i++) begin
            if (sel_s[i])                     w_d[i] = '0;
            else if (w_q[i] == WW'(MIN_PULSE)) w_d[i] = w_q[i];
            else                               w_d[i] = w_q[i] + WW'(1);
            glt_d[i] = ~sel_p_q[i] & sel_s[i] & (w_q[i] < WW'(MIN_PULSE));
        end
        rom_lo    = ~sel_s & ROM_MASK;
        multi_d   = |(rom_lo & (rom_lo - 8'd1));
        ramrom_d  = ~sel_s[7] & (|rom_lo);
        conf_p_d  = multi_q | ramrom_q;
        // AND with the previous sample so a runt's own line still shows low.
        vec_d     = sel_s & sel_p_q;
        was_run_d = (state_q == RUN);

        glt_n = '0;
        for (int i = 0; i < 8; i++) glt_n = glt_n + 4'(glt_q[i]);
        gsum       = {1'b0, glitch_cnt_q} + (CW+1)'(glt_n);
        // An already-active conflict is a new episode on the first RUN cycle.
        conf_start = (multi_q | ramrom_q) & (~conf_p_q | ~was_run_q);
        fault      = ~err_q & ((|glt_q) | conf_start);

        state_d        = state_q;
        glitch_cnt_d   = glitch_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        err_d          = err_q;
        err_type_d     = err_type_q;
        err_vec_d      = err_vec_q;

        if (clr_i) begin
            glitch_cnt_d   = '0;
            conflict_cnt_d = '0;
            err_d          = 1'b0;
            err_type_d     = 2'b00;
            err_vec_d      = 8'hFF;
            state_d        = en_i ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: if (en_i) state_d = RUN;
                RUN: begin
                    glitch_cnt_d = (gsum > {1'b0, CNT_MAX}) ? CNT_MAX : gsum[CW-1:0];
                    if (conf_start && conflict_cnt_q != CNT_MAX)
                        conflict_cnt_d = conflict_cnt_q + CW'(1);
                    if (fault) begin
                        err_d     = 1'b1;
                        err_vec_d = vec_q;
                        if (conf_start && ramrom_q)     err_type_d = 2'b11;
                        else if (conf_start && multi_q) err_type_d = 2'b10;
                        else                            err_type_d = 2'b01;
                    end
                    if (fault && FREEZE_ON_ERR != 0) state_d = HALT;
                    else if (!en_i)                  state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q         <= '1;
            sel_p_q        <= '1;
            w_q            <= '0;
            glt_q          <= '0;
            multi_q        <= 1'b0;
            ramrom_q       <= 1'b0;
            conf_p_q       <= 1'b0;
            was_run_q      <= 1'b0;
            vec_q          <= 8'hFF;
            state_q        <= IDLE;
            glitch_cnt_q   <= '0;
            conflict_cnt_q <= '0;
            err_q          <= 1'b0;
            err_type_q     <= 2'b00;
            err_vec_q      <= 8'hFF;
        end else begin
            sync_q         <= sync_d;
            sel_p_q        <= sel_p_d;
            w_q            <= w_d;
            glt_q          <= glt_d;
            multi_q        <= multi_d;
            ramrom_q       <= ramrom_d;
            conf_p_q       <= conf_p_d;
            was_run_q      <= was_run_d;
            vec_q          <= vec_d;
            state_q        <= state_d;
            glitch_cnt_q   <= glitch_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
            err_q          <= err_d;
            err_type_q     <= err_type_d;
            err_vec_q      <= err_vec_d;
        end
    end

    assign glitch_cnt_o   = glitch_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
    assign err_o          = err_q;
    assign err_type_o     = err_type_q;
    assign err_vec_o      = err_vec_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_pla_sel_monitor.sv
// Directed bench for pla_sel_monitor: three instances share stimulus
// (default/freeze, no-freeze, 4-bit counters); each task checks one of them.
module tb_pla_sel_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] sel = 8'hFF;

    logic [15:0] a_gc, a_cc, b_gc, b_cc;
    logic [3:0]  c_gc, c_cc;
    logic        a_err, b_err, c_err;
    logic [1:0]  a_typ, b_typ, c_typ, a_st, b_st, c_st;
    logic [7:0]  a_vec, b_vec, c_vec;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pla_sel_monitor #(.SYNC_STAGES(2), .MIN_PULSE(4), .CW(16), .FREEZE_ON_ERR(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .sel_n_i(sel),
        .glitch_cnt_o(a_gc), .conflict_cnt_o(a_cc), .err_o(a_err),
        .err_type_o(a_typ), .err_vec_o(a_vec), .state_o(a_st));

    pla_sel_monitor #(.SYNC_STAGES(2), .MIN_PULSE(4), .CW(16), .FREEZE_ON_ERR(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .sel_n_i(sel),
        .glitch_cnt_o(b_gc), .conflict_cnt_o(b_cc), .err_o(b_err),
        .err_type_o(b_typ), .err_vec_o(b_vec), .state_o(b_st));

    pla_sel_monitor #(.SYNC_STAGES(2), .MIN_PULSE(4), .CW(4), .FREEZE_ON_ERR(0)) dut_c (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .sel_n_i(sel),
        .glitch_cnt_o(c_gc), .conflict_cnt_o(c_cc), .err_o(c_err),
        .err_type_o(c_typ), .err_vec_o(c_vec), .state_o(c_st));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; sel = 8'hFF;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (a_gc !== 16'd0) begin $display("FAIL rst_glitch got=%0d exp=0", a_gc); n_bad++; end n_cmp++;
        if (a_cc !== 16'd0) begin $display("FAIL rst_conflict got=%0d exp=0", a_cc); n_bad++; end n_cmp++;
        if (a_err !== 1'b0) begin $display("FAIL rst_err got=%0b exp=0", a_err); n_bad++; end n_cmp++;
        if (a_typ !== 2'b00) begin $display("FAIL rst_type got=%0b exp=00", a_typ); n_bad++; end n_cmp++;
        if (a_vec !== 8'hFF) begin $display("FAIL rst_vec got=%0h exp=ff", a_vec); n_bad++; end n_cmp++;
        if (a_st !== 2'b00) begin $display("FAIL rst_state got=%0b exp=00", a_st); n_bad++; end n_cmp++;
        en = 1'b1;
        tick(1);
        if (a_st !== 2'b01) begin $display("FAIL idle_to_run got=%0b exp=01", a_st); n_bad++; end n_cmp++;
    endtask

    // IOn runt of 3 cycles with MIN_PULSE=4; also checks the 4-edge latency.
    task automatic test_glitch_freeze();
        do_reset();
        en = 1'b1;
        tick(3);
        sel = 8'hFB;
        tick(3);
        sel = 8'hFF;
        tick(3);
        if (a_gc !== 16'd0) begin $display("FAIL t1_early got=%0d exp=0", a_gc); n_bad++; end n_cmp++;
        tick(1);
        if (a_gc !== 16'd1) begin $display("FAIL t1_glitch got=%0d exp=1", a_gc); n_bad++; end n_cmp++;
        tick(4);
        if (a_err !== 1'b1) begin $display("FAIL t1_err got=%0b exp=1", a_err); n_bad++; end n_cmp++;
        if (a_typ !== 2'b01) begin $display("FAIL t1_type got=%0b exp=01", a_typ); n_bad++; end n_cmp++;
        if (a_vec !== 8'hFB) begin $display("FAIL t1_vec got=%0h exp=fb", a_vec); n_bad++; end n_cmp++;
        if (a_st !== 2'b10) begin $display("FAIL t1_state got=%0b exp=10", a_st); n_bad++; end n_cmp++;
        if (a_cc !== 16'd0) begin $display("FAIL t1_conflict got=%0d exp=0", a_cc); n_bad++; end n_cmp++;
    endtask

    // KERNALn+BASICn together, twice; then a conflict already active when RUN is entered.
    task automatic test_multi_rom();
        do_reset();
        en = 1'b1;
        tick(3);
        for (int r = 0; r < 2; r++) begin
            sel = 8'h9F; tick(10);
            sel = 8'hFF; tick(10);
        end
        if (b_cc !== 16'd2) begin $display("FAIL t2_conflict got=%0d exp=2", b_cc); n_bad++; end n_cmp++;
        if (b_gc !== 16'd0) begin $display("FAIL t2_glitch got=%0d exp=0", b_gc); n_bad++; end n_cmp++;
        if (b_typ !== 2'b10) begin $display("FAIL t2_type got=%0b exp=10", b_typ); n_bad++; end n_cmp++;
        if (b_vec !== 8'h9F) begin $display("FAIL t2_vec got=%0h exp=9f", b_vec); n_bad++; end n_cmp++;
        if (b_st !== 2'b01) begin $display("FAIL t2_state got=%0b exp=01", b_st); n_bad++; end n_cmp++;
        en = 1'b0;
        tick(2);
        if (b_st !== 2'b00) begin $display("FAIL t2_run_to_idle got=%0b exp=00", b_st); n_bad++; end n_cmp++;
        sel = 8'h9F; tick(6);
        if (b_cc !== 16'd2) begin $display("FAIL t2_idle_hold got=%0d exp=2", b_cc); n_bad++; end n_cmp++;
        en = 1'b1; tick(4);
        sel = 8'hFF; tick(6);
        if (b_cc !== 16'd3) begin $display("FAIL t2_enter_run got=%0d exp=3", b_cc); n_bad++; end n_cmp++;
    endtask

    // ROMLn runt ends in the same sample that CASRAMn+CHAROMn go low.
    task automatic test_priority();
        do_reset();
        en = 1'b1;
        tick(3);
        sel = 8'hFD; tick(2);
        sel = 8'h6F; tick(6);
        sel = 8'hFF; tick(6);
        if (a_typ !== 2'b11) begin $display("FAIL t3_type got=%0b exp=11", a_typ); n_bad++; end n_cmp++;
        if (a_cc !== 16'd1) begin $display("FAIL t3_conflict got=%0d exp=1", a_cc); n_bad++; end n_cmp++;
        if (a_gc !== 16'd1) begin $display("FAIL t3_glitch got=%0d exp=1", a_gc); n_bad++; end n_cmp++;
        if (a_vec !== 8'h6D) begin $display("FAIL t3_vec got=%0h exp=6d", a_vec); n_bad++; end n_cmp++;
        if (a_st !== 2'b10) begin $display("FAIL t3_state got=%0b exp=10", a_st); n_bad++; end n_cmp++;
    endtask

    // 4-bit counters: all-8 pulse adds 8, ROMHn pulses saturate at 15.
    task automatic test_saturation();
        do_reset();
        en = 1'b1;
        tick(3);
        sel = 8'h00; tick(1);
        sel = 8'hFF; tick(6);
        if (c_gc !== 4'd8) begin $display("FAIL t4_all8 got=%0d exp=8", c_gc); n_bad++; end n_cmp++;
        if (c_cc !== 4'd1) begin $display("FAIL t4_conf1 got=%0d exp=1", c_cc); n_bad++; end n_cmp++;
        if (c_typ !== 2'b11) begin $display("FAIL t4_type got=%0b exp=11", c_typ); n_bad++; end n_cmp++;
        if (c_vec !== 8'h00) begin $display("FAIL t4_vec got=%0h exp=00", c_vec); n_bad++; end n_cmp++;
        for (int p = 0; p < 20; p++) begin
            sel = 8'hFE; tick(1);
            sel = 8'hFF; tick(1);
        end
        tick(6);
        if (c_gc !== 4'd15) begin $display("FAIL t4_sat got=%0d exp=15", c_gc); n_bad++; end n_cmp++;
        sel = 8'h00; tick(1);
        sel = 8'hFF; tick(6);
        if (c_gc !== 4'd15) begin $display("FAIL t4_sat_add8 got=%0d exp=15", c_gc); n_bad++; end n_cmp++;
        if (c_cc !== 4'd2) begin $display("FAIL t4_conf2 got=%0d exp=2", c_cc); n_bad++; end n_cmp++;
        if (c_st !== 2'b01) begin $display("FAIL t4_state got=%0b exp=01", c_st); n_bad++; end n_cmp++;
    endtask

    // clr_i lands on the cycle a glitch would be counted; then HALT ignores en_i.
    task automatic test_clr_halt();
        do_reset();
        en = 1'b1;
        tick(3);
        sel = 8'hFB; tick(2);
        sel = 8'hFF; tick(3);
        clr = 1'b1; tick(1);
        clr = 1'b0;
        if (a_gc !== 16'd0) begin $display("FAIL t5_clr_glitch got=%0d exp=0", a_gc); n_bad++; end n_cmp++;
        if (a_err !== 1'b0) begin $display("FAIL t5_clr_err got=%0b exp=0", a_err); n_bad++; end n_cmp++;
        if (a_st !== 2'b01) begin $display("FAIL t5_clr_state got=%0b exp=01", a_st); n_bad++; end n_cmp++;
        tick(6);
        if (a_gc !== 16'd0) begin $display("FAIL t5_discard got=%0d exp=0", a_gc); n_bad++; end n_cmp++;
        if (a_st !== 2'b01) begin $display("FAIL t5_still_run got=%0b exp=01", a_st); n_bad++; end n_cmp++;
        sel = 8'hFB; tick(2);
        sel = 8'hFF; tick(6);
        if (a_st !== 2'b10) begin $display("FAIL t5_halt got=%0b exp=10", a_st); n_bad++; end n_cmp++;
        en = 1'b0; tick(3);
        if (a_st !== 2'b10) begin $display("FAIL t5_halt_en0 got=%0b exp=10", a_st); n_bad++; end n_cmp++;
        en = 1'b1; tick(3);
        sel = 8'hFB; tick(2);
        sel = 8'hFF; tick(6);
        if (a_st !== 2'b10) begin $display("FAIL t5_halt_en1 got=%0b exp=10", a_st); n_bad++; end n_cmp++;
        if (a_gc !== 16'd1) begin $display("FAIL t5_halt_frozen got=%0d exp=1", a_gc); n_bad++; end n_cmp++;
        en = 1'b0; clr = 1'b1; tick(1);
        clr = 1'b0;
        if (a_st !== 2'b00) begin $display("FAIL t5_clr_idle got=%0b exp=00", a_st); n_bad++; end n_cmp++;
        if (a_vec !== 8'hFF) begin $display("FAIL t5_clr_vec got=%0h exp=ff", a_vec); n_bad++; end n_cmp++;
    endtask

    // Reset with ROMHn low; released 2 cycles later so 2 low samples remain.
    task automatic test_reset_mid_pulse();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            en = 1'b1;
            tick(3);
            sel = 8'hFE; tick(3);
            en = (v == 0);
            rst = 1'b1; tick(1);
            if (a_gc !== 16'd0 || a_err !== 1'b0 || a_st !== 2'b00 || a_vec !== 8'hFF) begin
                $display("FAIL t6_reset got=gc%0d err%0b st%0b vec%0h exp=gc0 err0 st00 vecff",
                         a_gc, a_err, a_st, a_vec);
                n_bad++;
            end
            n_cmp++;
            rst = 1'b0; tick(2);
            sel = 8'hFF; tick(8);
            if (v == 0) begin
                if (a_gc !== 16'd1) begin $display("FAIL t6_run_glitch got=%0d exp=1", a_gc); n_bad++; end n_cmp++;
                if (a_vec !== 8'hFE) begin $display("FAIL t6_vec got=%0h exp=fe", a_vec); n_bad++; end n_cmp++;
                if (a_st !== 2'b10) begin $display("FAIL t6_state got=%0b exp=10", a_st); n_bad++; end n_cmp++;
            end else begin
                if (a_gc !== 16'd0) begin $display("FAIL t6_idle_glitch got=%0d exp=0", a_gc); n_bad++; end n_cmp++;
                if (a_st !== 2'b00) begin $display("FAIL t6_idle_state got=%0b exp=00", a_st); n_bad++; end n_cmp++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch_freeze();
        test_multi_rom();
        test_priority();
        test_saturation();
        test_clr_halt();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
